// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: load-data extraction, register-file write triple,
// stall/flush handling and the instret retire counter.
module mem_wb_stage #(
    parameter int unsigned data_size   = 32,
    parameter int unsigned log_reg_num = 5,
    parameter int unsigned cnt_w       = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_valid,
    input  logic                   mem_regwrite,
    input  logic                   mem_memtoreg,
    input  logic [log_reg_num-1:0] mem_rd,
    input  logic [data_size-1:0]   mem_alu_result,
    input  logic [data_size-1:0]   mem_load_word,
    input  logic [2:0]             mem_funct3,
    input  logic [1:0]             mem_addr_lo,
    input  logic                   stall,
    input  logic                   flush,
    output logic                   regwrite,
    output logic [log_reg_num-1:0] write_rd,
    output logic [data_size-1:0]   write_data,
    output logic                   wb_valid,
    output logic [cnt_w-1:0]       instret
);

    logic [7:0]           byte_val;
    logic [15:0]          half_val;
    logic [data_size-1:0] load_val;
    logic [data_size-1:0] sel_data;
    logic                 rd_nonzero;

    always_comb begin
        byte_val = '0;
        case (mem_addr_lo)
            2'd0:    byte_val = mem_load_word[7:0];
            2'd1:    byte_val = mem_load_word[15:8];
            2'd2:    byte_val = mem_load_word[23:16];
            default: byte_val = mem_load_word[31:24];
        endcase
        // Halfword lane depends only on addr_lo[1]; misaligned offsets are not trapped here.
        half_val = mem_addr_lo[1] ? mem_load_word[31:16] : mem_load_word[15:0];
    end

    always_comb begin
        load_val = mem_load_word;
        case (mem_funct3)
            3'b000:  load_val = {{(data_size-8){byte_val[7]}}, byte_val};
            3'b001:  load_val = {{(data_size-16){half_val[15]}}, half_val};
            3'b100:  load_val = {{(data_size-8){1'b0}}, byte_val};
            3'b101:  load_val = {{(data_size-16){1'b0}}, half_val};
            default: load_val = mem_load_word;
        endcase
        sel_data = mem_memtoreg ? load_val : mem_alu_result;
    end

    assign rd_nonzero = (mem_rd != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_valid   <= 1'b0;
            regwrite   <= 1'b0;
            write_rd   <= '0;
            write_data <= '0;
            instret    <= '0;
        end else if (flush) begin
            // Flush wins over stall; the rd/data lanes load but are meaningless with regwrite low.
            wb_valid   <= 1'b0;
            regwrite   <= 1'b0;
            write_rd   <= mem_rd;
            write_data <= sel_data;
        end else if (!stall) begin
            wb_valid   <= mem_valid;
            regwrite   <= mem_valid & mem_regwrite & rd_nonzero;
            write_rd   <= mem_rd;
            write_data <= sel_data;
            if (mem_valid) begin
                instret <= instret + cnt_w'(1);
            end
        end
    end

endmodule
